// File: rtl/sl_arb2_ctrl.sv
// Two-master round-robin arbiter in front of a same-latency request port.
// Write and read channels arbitrate independently; read responses route back via a fixed-latency tag line.
module sl_arb2_ctrl #(
  parameter  int RD_LAT = 4,
  parameter  int ADDR_W = 16,
  parameter  int DATA_W = 32,
  localparam int OUT_W  = $clog2(RD_LAT + 2),
  localparam int REQ_W  = 2 * ADDR_W + DATA_W + 2,
  localparam int RES_W  = DATA_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ_W-1:0] req_m0,
  output logic             wready_m0,
  output logic             rready_m0,
  output logic [RES_W-1:0] res_m0,
  input  logic [REQ_W-1:0] req_m1,
  output logic             wready_m1,
  output logic             rready_m1,
  output logic [RES_W-1:0] res_m1,
  output logic [REQ_W-1:0] req_down,
  input  logic [RES_W-1:0] res_down,
  output logic [OUT_W-1:0] rd_outst,
  output logic             err
);

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } wreq_t;

  typedef struct packed {
    logic              ren;
    logic [ADDR_W-1:0] raddr;
  } rreq_t;

  typedef struct packed {
    wreq_t wreq;
    rreq_t rreq;
  } req_t;

  typedef struct packed {
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
  } res_t;

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  typedef enum logic {
    PRI_M0 = 1'b0,
    PRI_M1 = 1'b1
  } pri_e;

  localparam int DEPTH = RD_LAT + 1;

  req_t m0, m1, down_q;
  res_t rsp;
  pri_e w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic w_gnt0, w_gnt1, r_gnt0, r_gnt1;
  tag_t [DEPTH-1:0] tags_q;
  tag_t push, head;
  logic hit;
  logic [OUT_W-1:0] outst_q;
  logic err_q;

  assign m0  = req_m0;
  assign m1  = req_m1;
  assign rsp = res_down;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr_q <= PRI_M0;
      r_ptr_q <= PRI_M0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
    end
  end

  // Pointer only moves on a contested cycle, handing priority to the loser.
  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    w_gnt0  = 1'b0;
    w_gnt1  = 1'b0;
    r_gnt0  = 1'b0;
    r_gnt1  = 1'b0;

    w_gnt0 = m0.wreq.wen && (!m1.wreq.wen || (w_ptr_q == PRI_M0));
    w_gnt1 = m1.wreq.wen && !w_gnt0;
    if (m0.wreq.wen && m1.wreq.wen) begin
      w_ptr_d = w_gnt0 ? PRI_M1 : PRI_M0;
    end

    r_gnt0 = m0.rreq.ren && (!m1.rreq.ren || (r_ptr_q == PRI_M0));
    r_gnt1 = m1.rreq.ren && !r_gnt0;
    if (m0.rreq.ren && m1.rreq.ren) begin
      r_ptr_d = r_gnt0 ? PRI_M1 : PRI_M0;
    end
  end

  assign wready_m0 = w_gnt0;
  assign wready_m1 = w_gnt1;
  assign rready_m0 = r_gnt0;
  assign rready_m1 = r_gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      down_q <= '0;
    end else begin
      down_q.wreq <= w_gnt0 ? m0.wreq : (w_gnt1 ? m1.wreq : '0);
      down_q.rreq <= r_gnt0 ? m0.rreq : (r_gnt1 ? m1.rreq : '0);
    end
  end

  assign req_down = down_q;

  // Tag pushed at grant reaches the head exactly when the tree returns its data.
  assign push.vld = r_gnt0 | r_gnt1;
  assign push.id  = r_gnt1;
  assign head     = tags_q[DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tags_q <= '0;
    end else begin
      tags_q <= {tags_q[DEPTH-2:0], push};
    end
  end

  assign hit    = rsp.rvalid && head.vld;
  assign res_m0 = (hit && !head.id) ? rsp : '0;
  assign res_m1 = (hit &&  head.id) ? rsp : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (rsp.rvalid != head.vld) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;

  // Every tag leaves the head one cycle after arriving there, so head.vld is the retire strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst_q <= '0;
    end else begin
      case ({push.vld, head.vld})
        2'b10:   outst_q <= outst_q + OUT_W'(1);
        2'b01:   outst_q <= outst_q - OUT_W'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  assign rd_outst = outst_q;

endmodule

// File: tb/tb_sl_arb2_ctrl.sv
// Directed self-checking bench for sl_arb2_ctrl (RD_LAT=4, 16-bit address, 32-bit data).
module tb_sl_arb2_ctrl;

  typedef struct packed {
    logic        wen;
    logic [15:0] waddr;
    logic [31:0] wdata;
  } wreq_t;

  typedef struct packed {
    logic        ren;
    logic [15:0] raddr;
  } rreq_t;

  typedef struct packed {
    wreq_t wreq;
    rreq_t rreq;
  } req_t;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
  } res_t;

  logic       clk;
  logic       rst;
  req_t       req_m0, req_m1, req_down;
  res_t       res_m0, res_m1, res_down;
  logic       wready_m0, rready_m0, wready_m1, rready_m1;
  logic [2:0] rd_outst;
  logic       err;

  int checks;
  int failures;

  sl_arb2_ctrl #(.RD_LAT(4), .ADDR_W(16), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_m0    (req_m0),
    .wready_m0 (wready_m0),
    .rready_m0 (rready_m0),
    .res_m0    (res_m0),
    .req_m1    (req_m1),
    .wready_m1 (wready_m1),
    .rready_m1 (rready_m1),
    .res_m1    (res_m1),
    .req_down  (req_down),
    .res_down  (res_down),
    .rd_outst  (rd_outst),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst      = 1'b1;
    req_m0   = '0;
    req_m1   = '0;
    res_down = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    req_m0   = '0;
    req_m1   = '0;
    res_down = '0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_down !== '0) begin
      failures++;
      $display("[TB] FAIL reset_req_down: got %h expected 0", req_down);
    end
    checks++;
    if (rd_outst !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_rd_outst: got %0d expected 0", rd_outst);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_err: got %b expected 0", err);
    end
    checks++;
    if (res_m0 !== '0 || res_m1 !== '0) begin
      failures++;
      $display("[TB] FAIL reset_res: got m0=%h m1=%h expected 0", res_m0, res_m1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_write;
    wreq_t exp_w;
    do_reset();
    exp_w = {1'b1, 16'h0010, 32'h0000_00AB};
    req_m0.wreq = exp_w;
    @(negedge clk);
    checks++;
    if ({wready_m0, wready_m1, rready_m0, rready_m1} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL single_write_ready: got w0,w1,r0,r1=%b expected 1000",
               {wready_m0, wready_m1, rready_m0, rready_m1});
    end
    cyc();
    req_m0 = '0;
    @(negedge clk);
    checks++;
    if (req_down.wreq !== exp_w || req_down.rreq !== '0) begin
      failures++;
      $display("[TB] FAIL single_write_down: got %h expected wreq=%h rreq=0", req_down, exp_w);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (req_down.wreq.wen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_write_idle: got wen=%b expected 0", req_down.wreq.wen);
    end
  endtask

  task automatic test_write_contention;
    int    n0;
    int    n1;
    logic  exp_id;
    logic  prev_ok;
    wreq_t prev_w;
    do_reset();
    n0 = 0;
    n1 = 0;
    prev_ok = 1'b0;
    prev_w  = '0;
    for (int i = 0; i < 6; i++) begin
      req_m0.wreq = {1'b1, 16'h0100, 32'hA000_0000 + 32'(n0)};
      req_m1.wreq = {1'b1, 16'h0200, 32'hB000_0000 + 32'(n1)};
      exp_id = (i % 2) == 1;
      @(negedge clk);
      checks++;
      if (wready_m0 !== ~exp_id || wready_m1 !== exp_id) begin
        failures++;
        $display("[TB] FAIL contention_grant[%0d]: got w0=%b w1=%b expected m%0d",
                 i, wready_m0, wready_m1, exp_id);
      end
      if (prev_ok) begin
        checks++;
        if (req_down.wreq !== prev_w) begin
          failures++;
          $display("[TB] FAIL contention_down[%0d]: got %h expected %h", i, req_down.wreq, prev_w);
        end
      end
      prev_w  = exp_id ? req_m1.wreq : req_m0.wreq;
      prev_ok = 1'b1;
      if (exp_id) n1++;
      else n0++;
      cyc();
    end
    req_m0 = '0;
    req_m1 = '0;
    @(negedge clk);
    checks++;
    if (req_down.wreq !== prev_w) begin
      failures++;
      $display("[TB] FAIL contention_down_last: got %h expected %h", req_down.wreq, prev_w);
    end
  endtask

  task automatic test_read_latency;
    rreq_t exp_r;
    do_reset();
    exp_r = {1'b1, 16'h0022};
    req_m1.rreq = exp_r;
    @(negedge clk);
    checks++;
    if (rready_m1 !== 1'b1 || rready_m0 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL read_ready: got r0=%b r1=%b expected r0=0 r1=1", rready_m0, rready_m1);
    end
    cyc();
    req_m1 = '0;
    @(negedge clk);
    checks++;
    if (req_down.rreq !== exp_r || rd_outst !== 3'd1) begin
      failures++;
      $display("[TB] FAIL read_down: got rreq=%h outst=%0d expected rreq=%h outst=1",
               req_down.rreq, rd_outst, exp_r);
    end
    for (int k = 2; k <= 4; k++) begin
      cyc();
      @(negedge clk);
      checks++;
      if (res_m1 !== '0 || rd_outst !== 3'd1) begin
        failures++;
        $display("[TB] FAIL read_wait[%0d]: got res_m1=%h outst=%0d expected 0 and 1",
                 k, res_m1, rd_outst);
      end
    end
    cyc();
    res_down = {1'b1, 32'h0000_0055};
    @(negedge clk);
    checks++;
    if (res_m1 !== {1'b1, 32'h0000_0055} || res_m0 !== '0) begin
      failures++;
      $display("[TB] FAIL read_route: got m0=%h m1=%h expected m0=0 m1=100000055", res_m0, res_m1);
    end
    cyc();
    res_down = '0;
    @(negedge clk);
    checks++;
    if (rd_outst !== 3'd0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL read_retire: got outst=%0d err=%b expected 0 0", rd_outst, err);
    end
  endtask

  task automatic test_mixed_channels;
    req_t exp_d;
    do_reset();
    req_m0.rreq = {1'b1, 16'h0033};
    req_m1.wreq = {1'b1, 16'h0044, 32'h0000_0099};
    exp_d = {1'b1, 16'h0044, 32'h0000_0099, 1'b1, 16'h0033};
    @(negedge clk);
    checks++;
    if ({wready_m0, wready_m1, rready_m0, rready_m1} !== 4'b0110) begin
      failures++;
      $display("[TB] FAIL mixed_ready: got w0,w1,r0,r1=%b expected 0110",
               {wready_m0, wready_m1, rready_m0, rready_m1});
    end
    cyc();
    req_m0 = '0;
    req_m1 = '0;
    @(negedge clk);
    checks++;
    if (req_down !== exp_d) begin
      failures++;
      $display("[TB] FAIL mixed_down: got %h expected %h", req_down, exp_d);
    end
    repeat (4) cyc();
    res_down = {1'b1, 32'h0000_0077};
    @(negedge clk);
    checks++;
    if (res_m0 !== {1'b1, 32'h0000_0077} || res_m1 !== '0) begin
      failures++;
      $display("[TB] FAIL mixed_route: got m0=%h m1=%h expected m0=100000077 m1=0", res_m0, res_m1);
    end
    cyc();
    res_down = '0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || rd_outst !== 3'd0) begin
      failures++;
      $display("[TB] FAIL mixed_retire: got err=%b outst=%0d expected 0 0", err, rd_outst);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    req_m0.rreq = {1'b1, 16'h0A00};
    req_m1.rreq = {1'b1, 16'h0B00};
    @(negedge clk);
    checks++;
    if (rready_m0 !== 1'b1 || rready_m1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_grant0: got r0=%b r1=%b expected 1 0", rready_m0, rready_m1);
    end
    cyc();
    req_m0.rreq = {1'b1, 16'h0A01};
    @(negedge clk);
    checks++;
    if (rready_m0 !== 1'b0 || rready_m1 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_grant1: got r0=%b r1=%b expected 0 1", rready_m0, rready_m1);
    end
    cyc();
    req_m0 = '0;
    req_m1 = '0;
    @(negedge clk);
    checks++;
    if (rd_outst !== 3'd2 || req_down.rreq !== {1'b1, 16'h0B00}) begin
      failures++;
      $display("[TB] FAIL b2b_outst: got outst=%0d rreq=%h expected 2 and 10b00",
               rd_outst, req_down.rreq);
    end
    repeat (3) cyc();
    res_down = {1'b1, 32'h0000_00C0};
    @(negedge clk);
    checks++;
    if (res_m0 !== {1'b1, 32'h0000_00C0} || res_m1 !== '0) begin
      failures++;
      $display("[TB] FAIL b2b_route0: got m0=%h m1=%h expected m0=1000000c0 m1=0", res_m0, res_m1);
    end
    cyc();
    res_down = {1'b1, 32'h0000_00C1};
    @(negedge clk);
    checks++;
    if (res_m1 !== {1'b1, 32'h0000_00C1} || res_m0 !== '0) begin
      failures++;
      $display("[TB] FAIL b2b_route1: got m0=%h m1=%h expected m0=0 m1=1000000c1", res_m0, res_m1);
    end
    cyc();
    res_down = '0;
    @(negedge clk);
    checks++;
    if (rd_outst !== 3'd0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_retire: got outst=%0d err=%b expected 0 0", rd_outst, err);
    end
  endtask

  task automatic test_unexpected_response;
    do_reset();
    res_down = {1'b1, 32'h0000_0012};
    @(negedge clk);
    checks++;
    if (res_m0 !== '0 || res_m1 !== '0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL unexp_drop: got m0=%h m1=%h err=%b expected 0 0 0", res_m0, res_m1, err);
    end
    cyc();
    res_down = '0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL unexp_err: got %b expected 1", err);
    end
    repeat (3) cyc();
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL unexp_sticky: got %b expected 1", err);
    end
  endtask

  task automatic test_reset_midflight;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      req_m0.rreq = {1'b1, 16'(i)};
      cyc();
    end
    req_m0 = '0;
    @(negedge clk);
    checks++;
    if (rd_outst !== 3'd3) begin
      failures++;
      $display("[TB] FAIL midflight_outst: got %0d expected 3", rd_outst);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rd_outst !== 3'd0 || req_down !== '0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midflight_async: got outst=%0d req_down=%h err=%b expected 0 0 0",
               rd_outst, req_down, err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    res_down = {1'b1, 32'h0000_00DD};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (res_m0 !== '0 || res_m1 !== '0) begin
        failures++;
        $display("[TB] FAIL midflight_drop[%0d]: got m0=%h m1=%h expected 0 0", i, res_m0, res_m1);
      end
      cyc();
    end
    res_down = '0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midflight_err: got %b expected 1", err);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req_m0   = '0;
    req_m1   = '0;
    res_down = '0;
    test_reset();
    test_single_write();
    test_write_contention();
    test_read_latency();
    test_mixed_channels();
    test_back_to_back();
    test_unexpected_response();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
